// File: rtl/gb_bus_responder.sv
// gb_bus_responder: memory-side T-state sequencer for the CPU bus-opcode protocol with wait states.
module gb_bus_responder #(
  parameter int ADDR_W     = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cpu_bus_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              mcycle_start,
  output logic              mcycle_end,
  output logic [7:0]        cpu_rdata,
  output logic              rdata_valid,
  output logic [7:0]        ir_data,
  output logic              ir_valid,
  output logic              ir_is_cb,
  output logic              bus_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [1:0] {T1, T2, T3, T4} tstate_t;
  localparam logic [2:0] OP_IDLE = 3'd0, OP_IF = 3'd1, OP_WRITE = 3'd2, OP_READ = 3'd3, OP_IF_CB = 3'd4;
  tstate_t    tstate;
  logic       run;
  logic [2:0] op_q;
  logic [7:0] wait_cnt;
  logic       op_ok, in_rd, stall, timeout;
  logic [7:0] cap;
  assign op_ok   = cpu_bus_op <= OP_IF_CB;
  assign in_rd   = cpu_bus_op == OP_IF || cpu_bus_op == OP_READ || cpu_bus_op == OP_IF_CB;
  assign stall   = tstate == T3 && op_q != OP_IDLE && !mem_ready;
  assign timeout = stall && wait_cnt >= 8'(WAIT_LIMIT);
  assign cap     = timeout ? 8'hFF : mem_rdata;
  // run delays the first T1 by one cycle so mcycle_start is never missed after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tstate <= T1;
      run <= 1'b0;
      op_q <= OP_IDLE;
      wait_cnt <= '0;
      mcycle_start <= 1'b0;
      mcycle_end <= 1'b0;
      cpu_rdata <= '0;
      rdata_valid <= 1'b0;
      ir_data <= '0;
      ir_valid <= 1'b0;
      ir_is_cb <= 1'b0;
      bus_fault <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      ir_valid <= 1'b0;
      mcycle_start <= 1'b0;
      mcycle_end <= 1'b0;
      if (!run) begin
        run <= 1'b1;
        tstate <= T1;
        mcycle_start <= 1'b1;
      end else begin
        case (tstate)
          T1: begin
            tstate <= T2;
            op_q <= op_ok ? cpu_bus_op : OP_IDLE;
            if (!op_ok) bus_fault <= 1'b1;
            if (op_ok && cpu_bus_op != OP_IDLE) mem_addr <= cpu_addr;
            if (cpu_bus_op == OP_WRITE) mem_wdata <= cpu_wdata;
            mem_wr <= cpu_bus_op == OP_WRITE;
            mem_rd <= in_rd;
          end
          T2: tstate <= T3;
          T3: begin
            if (stall && !timeout) begin
              wait_cnt <= wait_cnt + 8'd1;
            end else begin
              tstate <= T4;
              mcycle_end <= 1'b1;
              wait_cnt <= '0;
              mem_rd <= 1'b0;
              mem_wr <= 1'b0;
              if (timeout) bus_fault <= 1'b1;
              if (op_q == OP_READ) begin
                cpu_rdata <= cap;
                rdata_valid <= 1'b1;
              end
              if (op_q == OP_IF || op_q == OP_IF_CB) begin
                ir_data <= cap;
                ir_valid <= 1'b1;
                ir_is_cb <= op_q == OP_IF_CB;
              end
            end
          end
          T4: begin
            tstate <= T1;
            mcycle_start <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gb_bus_responder.sv
// tb_gb_bus_responder: table-driven directed bench for gb_bus_responder with WAIT_LIMIT=4.
module tb_gb_bus_responder;
  logic        clk = 0, rst_n;
  logic [2:0]  cpu_bus_op;
  logic [15:0] cpu_addr, mem_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, ir_data, mem_wdata, mem_rdata;
  logic        mcycle_start, mcycle_end, rdata_valid, ir_valid, ir_is_cb, bus_fault;
  logic        mem_rd, mem_wr, mem_ready;
  int checks = 0, failures = 0;

  gb_bus_responder #(.ADDR_W(16), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_bus_op(cpu_bus_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mcycle_start(mcycle_start), .mcycle_end(mcycle_end), .cpu_rdata(cpu_rdata), .rdata_valid(rdata_valid),
    .ir_data(ir_data), .ir_valid(ir_valid), .ir_is_cb(ir_is_cb), .bus_fault(bus_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          low;
    int          len;
    int          rds;
    int          wrs;
    logic [7:0]  exp_d;
    logic        exp_cb;
    logic        exp_fault;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {16'h0, mcycle_start, mcycle_end, cpu_rdata, rdata_valid, ir_data, ir_valid, ir_is_cb,
            bus_fault, mem_addr, mem_wdata, mem_rd, mem_wr};
  endfunction

  // Called at the falling edge of a T1 cycle; returns at the falling edge of the next T1.
  task automatic access(input vec_t v);
    int len, k, rds, wrs;
    bit done;
    check("t1_start", mcycle_start, 1);
    cpu_bus_op = v.op; cpu_addr = v.addr; cpu_wdata = v.wd;
    mem_ready = 0; mem_rdata = 8'hEE;
    len = 1; k = 0; rds = 0; wrs = 0; done = 0;
    while (!done && len < 40) begin
      @(negedge clk);
      len++;
      cpu_bus_op = 3'd6; cpu_addr = 16'hDEAD; cpu_wdata = 8'h99;
      if (mem_rd || mem_wr) begin
        k++;
        rds += int'(mem_rd); wrs += int'(mem_wr);
        if (k == 1) begin
          check("mem_addr", mem_addr, v.addr);
          if (v.op == 3'd2) check("mem_wdata", mem_wdata, v.wd);
        end
        mem_ready = k >= v.low + 2;
        mem_rdata = mem_ready ? v.rd : 8'hEE;
      end
      if (mcycle_end) done = 1;
    end
    check("mcycle_len", len, v.len);
    check("rd_cycles", rds, v.rds);
    check("wr_cycles", wrs, v.wrs);
    check("rdata_valid", rdata_valid, v.op == 3'd3);
    check("ir_valid", ir_valid, v.op == 3'd1 || v.op == 3'd4);
    if (v.op == 3'd3) check("cpu_rdata", cpu_rdata, v.exp_d);
    if (v.op == 3'd1 || v.op == 3'd4) begin
      check("ir_data", ir_data, v.exp_d);
      check("ir_is_cb", ir_is_cb, v.exp_cb);
    end
    check("bus_fault", bus_fault, v.exp_fault);
    @(negedge clk);
    check("next_start", {mcycle_start, rdata_valid, ir_valid}, 3'b100);
  endtask

  initial begin
    //         op    addr      wd     rd     low len rds wrs exp_d  cb fault
    tbl[0] = '{3'd3, 16'hC123, 8'h00, 8'h5A, 0,  4,  2,  0, 8'h5A, 0, 0};
    tbl[1] = '{3'd2, 16'hFF80, 8'h3C, 8'h00, 0,  4,  0,  2, 8'h00, 0, 0};
    tbl[2] = '{3'd4, 16'h0101, 8'h00, 8'h37, 0,  4,  2,  0, 8'h37, 1, 0};
    tbl[3] = '{3'd1, 16'h0102, 8'h00, 8'h00, 0,  4,  2,  0, 8'h00, 0, 0};
    tbl[4] = '{3'd3, 16'h1234, 8'h00, 8'hA5, 3,  7,  5,  0, 8'hA5, 0, 0};
    tbl[5] = '{3'd0, 16'h5555, 8'h00, 8'h00, 0,  4,  0,  0, 8'h00, 0, 0};
    tbl[6] = '{3'd6, 16'h6666, 8'h00, 8'h00, 0,  4,  0,  0, 8'h00, 0, 1};
    tbl[7] = '{3'd3, 16'h4000, 8'h00, 8'h77, 99, 8,  6,  0, 8'hFF, 0, 1};
    tbl[8] = '{3'd3, 16'h2000, 8'h00, 8'h81, 0,  4,  2,  0, 8'h81, 0, 1};
    tbl[9] = '{3'd1, 16'h0200, 8'h00, 8'hC3, 1,  5,  3,  0, 8'hC3, 0, 1};
    rst_n = 0; cpu_bus_op = 3'd3; cpu_addr = 16'h1111; cpu_wdata = 0; mem_rdata = 8'hEE; mem_ready = 1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", all_outs(), 0);
    end
    rst_n = 1;
    @(negedge clk);
    check("first_start", mcycle_start, 1);
    for (int i = 0; i <= 6; i++) access(tbl[i]);
    rst_n = 0;
    @(negedge clk);
    check("fault_cleared", {bus_fault, mcycle_start, mem_rd, mem_wr}, 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 7; i <= 9; i++) access(tbl[i]);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("t1_midrst", mcycle_start, 1);
    cpu_bus_op = 3'd2; cpu_addr = 16'h8000; cpu_wdata = 8'h11; mem_ready = 1;
    @(negedge clk);
    check("midrst_wr_t2", mem_wr, 1);
    @(negedge clk);
    check("midrst_wr_t3", mem_wr, 1);
    rst_n = 0;
    @(negedge clk);
    check("midrst_abort", {mem_wr, mem_rd, mcycle_start, mcycle_end}, 0);
    rst_n = 1;
    @(negedge clk);
    access(tbl[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
